// File: rtl/controle_acesso.sv
// Access sequencing for the digital lock: counts consecutive PIN failures,
// times the lockout and unlock windows, grants setup mode on the master PIN.
module controle_acesso #(
  parameter int MAX_TENT = 3,
  parameter int T_TRAVA  = 5,
  parameter int T_BLOQ   = 30,
  parameter int TW       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          senha_fail,
  input  logic                          senha_padrao,
  input  logic                          senha_master,
  input  logic                          setup_done,
  output logic                          tranca_aberta,
  output logic                          bloqueado,
  output logic                          modo_setup,
  output logic [$clog2(MAX_TENT+1)-1:0] tentativas,
  output logic [TW-1:0]                 tempo_restante,
  output logic                          pin_clear
);

  localparam int CW = $clog2(MAX_TENT+1);

  typedef enum logic [1:0] {
    IDLE,
    ABERTO,
    BLOQUEADO,
    SETUP
  } estado_t;

  estado_t       estado;
  estado_t       estado_nx;
  logic          prev_fail;
  logic          prev_padrao;
  logic          prev_master;
  logic          ev_fail;
  logic          ev_padrao;
  logic          ev_master;
  logic [TW-1:0] timer_nx;
  logic [CW-1:0] cnt_nx;
  logic          clr_nx;

  // Verifier flags are level-held; only their rising edges count as verdicts.
  always_comb begin
    ev_fail   = senha_fail   & ~prev_fail;
    ev_padrao = senha_padrao & ~prev_padrao;
    ev_master = senha_master & ~prev_master;
  end

  always_comb begin
    estado_nx = estado;
    timer_nx  = tempo_restante;
    cnt_nx    = tentativas;
    clr_nx    = 1'b0;
    case (estado)
      IDLE: begin
        timer_nx = '0;
        if (ev_master) begin
          estado_nx = SETUP;
          cnt_nx    = '0;
          clr_nx    = 1'b1;
        end else if (ev_padrao) begin
          estado_nx = ABERTO;
          timer_nx  = TW'(T_TRAVA);
          cnt_nx    = '0;
          clr_nx    = 1'b1;
        end else if (ev_fail) begin
          clr_nx = 1'b1;
          if (int'(tentativas) + 1 < MAX_TENT) begin
            cnt_nx = tentativas + CW'(1);
          end else begin
            estado_nx = BLOQUEADO;
            timer_nx  = TW'(T_BLOQ);
            cnt_nx    = '0;
          end
        end
      end
      ABERTO: begin
        // A fresh padrao verdict extends the window even if master rose with it;
        // master itself has no effect here. Reload takes precedence over tick.
        if (ev_padrao) begin
          timer_nx = TW'(T_TRAVA);
          clr_nx   = 1'b1;
        end else if (tick) begin
          if (tempo_restante > TW'(1)) begin
            timer_nx = tempo_restante - TW'(1);
          end else begin
            timer_nx  = '0;
            estado_nx = IDLE;
          end
        end
      end
      BLOQUEADO: begin
        cnt_nx = '0;
        if (tick) begin
          if (tempo_restante > TW'(1)) begin
            timer_nx = tempo_restante - TW'(1);
          end else begin
            timer_nx  = '0;
            estado_nx = IDLE;
          end
        end
      end
      SETUP: begin
        timer_nx = '0;
        if (setup_done) begin
          estado_nx = IDLE;
        end
      end
      default: begin
        estado_nx = IDLE;
        timer_nx  = '0;
        cnt_nx    = '0;
      end
    endcase
  end

  // Status outputs are registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado         <= IDLE;
      prev_fail      <= 1'b0;
      prev_padrao    <= 1'b0;
      prev_master    <= 1'b0;
      tempo_restante <= '0;
      tentativas     <= '0;
      pin_clear      <= 1'b0;
      tranca_aberta  <= 1'b0;
      bloqueado      <= 1'b0;
      modo_setup     <= 1'b0;
    end else begin
      estado         <= estado_nx;
      prev_fail      <= senha_fail;
      prev_padrao    <= senha_padrao;
      prev_master    <= senha_master;
      tempo_restante <= timer_nx;
      tentativas     <= cnt_nx;
      pin_clear      <= clr_nx;
      tranca_aberta  <= (estado_nx == ABERTO);
      bloqueado      <= (estado_nx == BLOQUEADO);
      modo_setup     <= (estado_nx == SETUP);
    end
  end

endmodule

// File: doc/controle_acesso.md
# controle_acesso

Access-sequencing controller for the digital lock. It sits downstream of the password verifier and consumes that block's level-held result flags (`senha_fail`, `senha_padrao`, `senha_master`). It counts consecutive failures, enforces a timed lockout, and holds the bolt open for a timed window. It also grants setup mode on a master PIN and pulses a clear to the PIN-entry logic after every accepted verdict.

## Interface
Parameters:
- `MAX_TENT`, default 3: consecutive failures that trigger lockout (≥1).
- `T_TRAVA`, default 5: unlock window, in `tick` periods (≥1).
- `T_BLOQ`, default 30: lockout duration, in `tick` periods (≥1).
- `TW`, default 8: timer width; must hold max(`T_TRAVA`, `T_BLOQ`).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (low = reset).
- `tick`  in  1  one-cycle time-base strobe (e.g. 1 s).
- `senha_fail`  in  1  verifier flag, level, held while PIN status is high.
- `senha_padrao`  in  1  verifier flag, level.
- `senha_master`  in  1  verifier flag, level.
- `setup_done`  in  1  one-cycle pulse from setup logic; ends setup mode.
- `tranca_aberta`  out  1  bolt release, high in ABERTO.
- `bloqueado`  out  1  high in BLOQUEADO.
- `modo_setup`  out  1  high in SETUP.
- `tentativas`  out  $clog2(MAX_TENT+1)  current consecutive-failure count.
- `tempo_restante`  out  TW  active timer value; 0 in IDLE/SETUP.
- `pin_clear`  out  1  one-cycle pulse after each accepted verdict.

## Operation
- Edge detection: three registers hold the previous values of the three flags. An event is flag=1 with prev=0. Prev registers update every cycle in all states, so a level held across a state change never re-fires.
- Simultaneous events are resolved by priority: master > padrao > fail. Only one event is accepted per cycle.
- States are IDLE, ABERTO, BLOQUEADO, SETUP. Outputs are registered and decoded from the state.
- IDLE:
  - master event → SETUP; `tentativas`←0.
  - padrao event → ABERTO; timer←`T_TRAVA`; `tentativas`←0.
  - fail event with `tentativas`+1 < `MAX_TENT` → `tentativas`++; stay in IDLE.
  - fail event with `tentativas`+1 = `MAX_TENT` → BLOQUEADO; timer←`T_BLOQ`; `tentativas`←0.
- ABERTO:
  - padrao event → timer reloads to `T_TRAVA`; `pin_clear` pulses.
  - master and fail events are ignored: no count, no `pin_clear`.
- BLOQUEADO: all events are ignored, including master. `tentativas` stays 0.
- SETUP:
  - `setup_done` → IDLE.
  - Verifier events are ignored.
  - No timeout.
- Timer: on `tick` with timer>1, decrement. On `tick` with timer=1, set timer←0 and leave ABERTO/BLOQUEADO for IDLE on the same edge. On entry to IDLE or SETUP, timer←0.
- Reload and tick in the same cycle: the reload wins and no decrement occurs.
- `pin_clear` pulses exactly when an event is accepted, i.e. one that causes a transition, a count change, or a reload.
- Reset mid-operation: state, timer, count and prev registers clear immediately. A flag that is already high when reset releases is seen as an event on the first clock edge after release.

## Timing
- Reset values:
  - state = IDLE.
  - `tranca_aberta`=0, `bloqueado`=0, `modo_setup`=0.
  - `tentativas`=0, `tempo_restante`=0, `pin_clear`=0.
  - Prev registers = 0.
- Latency: a flag first sampled high at edge N gives its outputs (state, counters, `pin_clear`) valid after edge N. That is one cycle of latency, with no combinational input-to-output path.
- ABERTO lasts from the entry edge until the edge of the `T_TRAVA`-th subsequent `tick`. BLOQUEADO behaves the same way with `T_BLOQ`.
- `pin_clear` is high for exactly one cycle per accepted event.
- `tempo_restante` equals the internal timer register with no lag.

## Test plan
All scenarios use `MAX_TENT`=3, `T_TRAVA`=2, `T_BLOQ`=4, and `tick` every 10 cycles.

1. Reset: drive `rst`=0 mid-ABERTO → all outputs read 0 in the same cycle. Release and assert `senha_padrao` → ABERTO one edge later, `tempo_restante`=2.
2. Three separate `senha_fail` pulses, each held 5 cycles → `tentativas` reads 1, 2, then 0 with `bloqueado`=1 and `tempo_restante`=4. Each pulse gives one `pin_clear`.
3. In BLOQUEADO, pulse `senha_master` and `senha_padrao` → no change and no `pin_clear`. After the 4th `tick`, state is IDLE and `bloqueado`=0.
4. Two fails, then padrao → ABERTO with `tentativas`=0. A second padrao between the ticks → timer reloads to 2. After 2 more ticks the state is IDLE.
5. `senha_master` and `senha_fail` rise together in IDLE → SETUP, `modo_setup`=1, `tentativas`=0, one `pin_clear`. Then pulse `setup_done` → IDLE.
6. `senha_padrao` entry in the same cycle as a `tick` → `tempo_restante`=2, with no decrement applied.
